// File: rtl/exec_stage_if.sv
// Bundles the decode-to-execute operand/control signals and the execute outputs.
// Latency: wiring only.
// Backpressure: carries stall/flush from the hazard unit. There is no ready signal.
interface exec_stage_if;
    // decode-side inputs to the execute stage
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [63:0] pc_in;
    logic [3:0]  alu_op;
    logic [3:0]  trap_cause_in;
    logic [11:0] csr_addr;
    logic        is_csr;
    logic        csr_read;
    logic        csr_write;
    logic        trap_in;
    logic        reg_write_enable;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        jump;
    logic        use_pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        stall;
    logic        flush;
    logic [63:0] csr_rdata;

    // EX/MEM register outputs
    logic [11:0] csr_addr_out;
    logic [63:0] csr_wdata;
    logic        csr_read_out;
    logic        csr_write_out;
    logic [63:0] alu_result;
    logic [63:0] rs2_data_out;
    logic [63:0] pc_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3_out;
    logic        reg_write_enable_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [3:0]  trap_cause_out;
    logic        trap_out;

    // same-cycle control-flow and exception outputs
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        jump_taken;
    logic [63:0] jump_target;
    logic        exception_occurred;
    logic [63:0] exception_pc;
    logic [3:0]  exception_cause;

    modport master (
        output opcode, rd, rs1, rs2, funct3, funct7, imm, pc_in, alu_op, trap_cause_in,
               csr_addr, is_csr, csr_read, csr_write, trap_in, reg_write_enable,
               mem_read, mem_write, is_branch, jump, use_pc, rs1_data, rs2_data,
               stall, flush, csr_rdata,
        input  csr_addr_out, csr_wdata, csr_read_out, csr_write_out, alu_result,
               rs2_data_out, pc_out, rd_out, funct3_out, reg_write_enable_out,
               mem_read_out, mem_write_out, trap_cause_out, trap_out,
               branch_taken, branch_target, jump_taken, jump_target,
               exception_occurred, exception_pc, exception_cause
    );

    modport slave (
        input  opcode, rd, rs1, rs2, funct3, funct7, imm, pc_in, alu_op, trap_cause_in,
               csr_addr, is_csr, csr_read, csr_write, trap_in, reg_write_enable,
               mem_read, mem_write, is_branch, jump, use_pc, rs1_data, rs2_data,
               stall, flush, csr_rdata,
        output csr_addr_out, csr_wdata, csr_read_out, csr_write_out, alu_result,
               rs2_data_out, pc_out, rd_out, funct3_out, reg_write_enable_out,
               mem_read_out, mem_write_out, trap_cause_out, trap_out,
               branch_taken, branch_target, jump_taken, jump_target,
               exception_occurred, exception_pc, exception_cause
    );
endinterface

// File: rtl/exec_stage.sv
// RV64I/Zicsr execute stage: ALU, branch/jump resolution, CSR write data, EX/MEM register.
// Latency: control-flow and exception outputs are combinational; EX/MEM fields take 1 cycle.
// Backpressure: stall holds the EX/MEM register, flush inserts a bubble, and both blank the combinational outputs.
module exec_stage #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         resetn,
    exec_stage_if.slave  io
);
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG_W  = 7'b0111011;
    localparam logic [6:0] OP_IMM_W  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            is_w;
    logic [5:0]      shamt;
    logic [4:0]      shamt_w;
    logic [31:0]     a32;
    logic [31:0]     b32;
    logic [31:0]     w32;
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] result_val;

    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jump_tgt;
    logic            br_cond;
    logic            br_hit;
    logic            misaligned;
    logic            exc;
    logic [3:0]      exc_cause;
    logic            kill;

    logic [XLEN-1:0] csr_src;
    logic [XLEN-1:0] csr_wdata_val;

    // Operand selection. Only register-register forms take rs2; all others use the immediate.
    assign op_a    = io.use_pc ? io.pc_in : io.rs1_data;
    assign op_b    = (io.opcode == OP_REG || io.opcode == OP_REG_W) ? io.rs2_data : io.imm;
    assign is_w    = (io.opcode == OP_IMM_W || io.opcode == OP_REG_W);
    assign shamt   = op_b[5:0];
    assign shamt_w = op_b[4:0];
    assign a32     = op_a[31:0];
    assign b32     = op_b[31:0];

    // ALU. W-ops compute on the low word and sign-extend bit 31; unused op codes give 0.
    always_comb begin
        alu_val = '0;
        w32     = '0;
        if (is_w) begin
            case (io.alu_op)
                4'd0:    w32 = a32 + b32;
                4'd1:    w32 = a32 - b32;
                4'd2:    w32 = a32 << shamt_w;
                4'd3:    w32 = {31'b0, $signed(a32) < $signed(b32)};
                4'd4:    w32 = {31'b0, a32 < b32};
                4'd5:    w32 = a32 ^ b32;
                4'd6:    w32 = a32 >> shamt_w;
                4'd7:    w32 = $unsigned($signed(a32) >>> shamt_w);
                4'd8:    w32 = a32 | b32;
                4'd9:    w32 = a32 & b32;
                4'd10:   w32 = b32;
                default: w32 = '0;
            endcase
            alu_val = {{32{w32[31]}}, w32};
        end else begin
            case (io.alu_op)
                4'd0:    alu_val = op_a + op_b;
                4'd1:    alu_val = op_a - op_b;
                4'd2:    alu_val = op_a << shamt;
                4'd3:    alu_val = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                4'd4:    alu_val = {{(XLEN-1){1'b0}}, op_a < op_b};
                4'd5:    alu_val = op_a ^ op_b;
                4'd6:    alu_val = op_a >> shamt;
                4'd7:    alu_val = $unsigned($signed(op_a) >>> shamt);
                4'd8:    alu_val = op_a | op_b;
                4'd9:    alu_val = op_a & op_b;
                4'd10:   alu_val = op_b;
                default: alu_val = '0;
            endcase
        end
    end

    // Link address wins over CSR read data, which wins over the ALU.
    assign pc_plus_4  = io.pc_in + 64'd4;
    assign result_val = io.jump ? pc_plus_4 : (io.is_csr ? io.csr_rdata : alu_val);

    // Branch condition always compares the raw register operands.
    always_comb begin
        br_cond = 1'b0;
        case (io.funct3)
            3'b000:  br_cond = (io.rs1_data == io.rs2_data);
            3'b001:  br_cond = (io.rs1_data != io.rs2_data);
            3'b100:  br_cond = ($signed(io.rs1_data) <  $signed(io.rs2_data));
            3'b101:  br_cond = ($signed(io.rs1_data) >= $signed(io.rs2_data));
            3'b110:  br_cond = (io.rs1_data <  io.rs2_data);
            3'b111:  br_cond = (io.rs1_data >= io.rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    // Targets. JALR clears bit 0 of the target, and bit 1 set on a taken path is misaligned.
    assign pc_plus_imm = io.pc_in + io.imm;
    assign jalr_sum    = io.rs1_data + io.imm;
    assign jump_tgt    = (io.opcode == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_plus_imm;
    assign br_hit      = io.is_branch & br_cond;
    assign misaligned  = (br_hit & pc_plus_imm[1]) | (io.jump & jump_tgt[1]);
    assign exc         = io.trap_in | misaligned;
    assign exc_cause   = io.trap_in ? io.trap_cause_in : 4'd0;
    assign kill        = io.stall | io.flush;

    // CSR write data. The I-forms take the zero-extended rs1 index as the source.
    assign csr_src = io.funct3[2] ? {{(XLEN-5){1'b0}}, io.rs1} : io.rs1_data;
    always_comb begin
        csr_wdata_val = '0;
        case (io.funct3[1:0])
            2'b01:   csr_wdata_val = csr_src;
            2'b10:   csr_wdata_val = io.csr_rdata | csr_src;
            2'b11:   csr_wdata_val = io.csr_rdata & ~csr_src;
            default: csr_wdata_val = '0;
        endcase
    end

    // Same-cycle redirect/exception outputs, blanked while stalled or flushed.
    always_comb begin
        io.branch_taken       = 1'b0;
        io.branch_target      = '0;
        io.jump_taken         = 1'b0;
        io.jump_target        = '0;
        io.exception_occurred = 1'b0;
        io.exception_pc       = '0;
        io.exception_cause    = '0;
        if (!kill) begin
            io.branch_taken       = br_hit & ~misaligned;
            io.branch_target      = pc_plus_imm;
            io.jump_taken         = io.jump & ~misaligned;
            io.jump_target        = jump_tgt;
            io.exception_occurred = exc;
            io.exception_pc       = io.pc_in;
            io.exception_cause    = exc_cause;
        end
    end

    // EX/MEM register: reset, then bubble, then hold, then load. An excepting instruction loses its side effects.
    always_ff @(posedge clk) begin
        if (resetn || io.flush) begin
            io.csr_addr_out         <= '0;
            io.csr_wdata            <= '0;
            io.csr_read_out         <= 1'b0;
            io.csr_write_out        <= 1'b0;
            io.alu_result           <= '0;
            io.rs2_data_out         <= '0;
            io.pc_out               <= '0;
            io.rd_out               <= '0;
            io.funct3_out           <= '0;
            io.reg_write_enable_out <= 1'b0;
            io.mem_read_out         <= 1'b0;
            io.mem_write_out        <= 1'b0;
            io.trap_cause_out       <= '0;
            io.trap_out             <= 1'b0;
        end else if (!io.stall) begin
            io.csr_addr_out         <= io.csr_addr;
            io.csr_wdata            <= csr_wdata_val;
            io.csr_read_out         <= io.csr_read;
            io.csr_write_out        <= io.csr_write & ~exc;
            io.alu_result           <= result_val;
            io.rs2_data_out         <= io.rs2_data;
            io.pc_out               <= io.pc_in;
            io.rd_out               <= io.rd;
            io.funct3_out           <= io.funct3;
            io.reg_write_enable_out <= io.reg_write_enable & ~exc;
            io.mem_read_out         <= io.mem_read & ~exc;
            io.mem_write_out        <= io.mem_write & ~exc;
            io.trap_cause_out       <= exc_cause;
            io.trap_out             <= exc;
        end
    end

    // funct7 and the rs2 index are carried for decode only; bit 0 of the JALR sum is discarded.
    logic unused_bits;
    assign unused_bits = ^{io.funct7, io.rs2, jalr_sum[0]};
endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    exec_stage_if ex_if ();
    exec_stage #(.XLEN(64)) dut (.clk(clk), .resetn(resetn), .io(ex_if));

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] csr_rdata;
        logic [11:0] csr_addr;
        logic        is_branch;
        logic        jump;
        logic        use_pc;
        logic        is_csr;
        logic        csr_read;
        logic        csr_write;
        logic        trap_in;
        logic [3:0]  trap_cause;
        logic        rwe;
        logic        mem_read;
        logic        mem_write;
        logic [63:0] e_alu;
        logic [63:0] e_csrw;
        logic        e_bt;
        logic [63:0] e_btgt;
        logic        e_jt;
        logic [63:0] e_jtgt;
        logic        e_exc;
        logic [3:0]  e_cause;
    } vec_t;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] csrw;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [63:0] pc;
        logic [63:0] rs2;
        logic [11:0] caddr;
        logic        cr;
        logic        cw;
        logic        rwe;
        logic        mr;
        logic        mw;
        logic        trap;
        logic [3:0]  cause;
    } reg_t;

    vec_t vecs[$];
    reg_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic reg_t exp_of(input vec_t v);
        reg_t r;
        r.alu   = v.e_alu;
        r.csrw  = v.e_csrw;
        r.rd    = v.rd;
        r.f3    = v.funct3;
        r.pc    = v.pc;
        r.rs2   = v.rs2_data;
        r.caddr = v.csr_addr;
        r.cr    = v.csr_read;
        r.cw    = v.csr_write & ~v.e_exc;
        r.rwe   = v.rwe & ~v.e_exc;
        r.mr    = v.mem_read & ~v.e_exc;
        r.mw    = v.mem_write & ~v.e_exc;
        r.trap  = v.e_exc;
        r.cause = v.e_cause;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        ex_if.opcode           = v.opcode;
        ex_if.funct3           = v.funct3;
        ex_if.funct7           = 7'd0;
        ex_if.alu_op           = v.alu_op;
        ex_if.rd               = v.rd;
        ex_if.rs1              = v.rs1;
        ex_if.rs2              = 5'd0;
        ex_if.imm              = v.imm;
        ex_if.pc_in            = v.pc;
        ex_if.rs1_data         = v.rs1_data;
        ex_if.rs2_data         = v.rs2_data;
        ex_if.csr_rdata        = v.csr_rdata;
        ex_if.csr_addr         = v.csr_addr;
        ex_if.is_branch        = v.is_branch;
        ex_if.jump             = v.jump;
        ex_if.use_pc           = v.use_pc;
        ex_if.is_csr           = v.is_csr;
        ex_if.csr_read         = v.csr_read;
        ex_if.csr_write        = v.csr_write;
        ex_if.trap_in          = v.trap_in;
        ex_if.trap_cause_in    = v.trap_cause;
        ex_if.reg_write_enable = v.rwe;
        ex_if.mem_read         = v.mem_read;
        ex_if.mem_write        = v.mem_write;
    endtask

    task automatic check_regs(input string tag, input reg_t r);
        chk({tag, ".alu_result"}, ex_if.alu_result, r.alu);
        chk({tag, ".csr_wdata"}, ex_if.csr_wdata, r.csrw);
        chk({tag, ".rd_out"}, {59'd0, ex_if.rd_out}, {59'd0, r.rd});
        chk({tag, ".funct3_out"}, {61'd0, ex_if.funct3_out}, {61'd0, r.f3});
        chk({tag, ".pc_out"}, ex_if.pc_out, r.pc);
        chk({tag, ".rs2_data_out"}, ex_if.rs2_data_out, r.rs2);
        chk({tag, ".csr_addr_out"}, {52'd0, ex_if.csr_addr_out}, {52'd0, r.caddr});
        chk({tag, ".ctl_out"},
            {58'd0, ex_if.csr_read_out, ex_if.csr_write_out, ex_if.reg_write_enable_out,
             ex_if.mem_read_out, ex_if.mem_write_out, ex_if.trap_out},
            {58'd0, r.cr, r.cw, r.rwe, r.mr, r.mw, r.trap});
        chk({tag, ".trap_cause_out"}, {60'd0, ex_if.trap_cause_out}, {60'd0, r.cause});
    endtask

    task automatic check_comb(input string tag, input vec_t v, input logic blank);
        chk({tag, ".branch_taken"}, {63'd0, ex_if.branch_taken}, blank ? 64'd0 : {63'd0, v.e_bt});
        chk({tag, ".branch_target"}, ex_if.branch_target, blank ? 64'd0 : v.e_btgt);
        chk({tag, ".jump_taken"}, {63'd0, ex_if.jump_taken}, blank ? 64'd0 : {63'd0, v.e_jt});
        chk({tag, ".jump_target"}, ex_if.jump_target, blank ? 64'd0 : v.e_jtgt);
        chk({tag, ".exception_occurred"}, {63'd0, ex_if.exception_occurred}, blank ? 64'd0 : {63'd0, v.e_exc});
        chk({tag, ".exception_cause"}, {60'd0, ex_if.exception_cause}, blank ? 64'd0 : {60'd0, v.e_cause});
        chk({tag, ".exception_pc"}, ex_if.exception_pc, blank ? 64'd0 : v.pc);
    endtask

    // Drive one vector, check the combinational view, then check what the EX/MEM register captured.
    task automatic apply(input string tag, input vec_t v);
        reg_t r;
        @(negedge clk);
        drive(v);
        ex_if.stall = 1'b0;
        ex_if.flush = 1'b0;
        #1;
        check_comb(tag, v, 1'b0);
        sb.push_back(exp_of(v));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
        end else begin
            r = sb.pop_front();
            check_regs(tag, r);
        end
    endtask

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] RW = 7'b0111011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] IW = 7'b0011011;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        vec_t v_add, v_blt, v;
        reg_t r_add, zero_r;
        logic [63:0] a, b, e;
        int op;

        zero_r = '0;
        v_add = '{opcode:R, alu_op:4'd0, rs1_data:64'd5, rs2_data:64'hFFFF_FFFF_FFFF_FFF9, rd:5'd3, rwe:1'b1,
                  pc:64'h1000, e_alu:64'hFFFF_FFFF_FFFF_FFFE, e_btgt:64'h1000, e_jtgt:64'h1000, default:'0};
        v_blt = '{opcode:7'b1100011, funct3:3'b100, is_branch:1'b1, rs1_data:M1, rs2_data:64'd1, pc:64'h100,
                  imm:64'h20, e_alu:64'h1F, e_bt:1'b1, e_btgt:64'h120, e_jtgt:64'h120, default:'0};

        vecs.push_back(v_add);
        vecs.push_back('{opcode:R, alu_op:4'd1, rs1_data:64'd10, rs2_data:64'd3, pc:64'h2000, rd:5'd4, rwe:1'b1,
                         e_alu:64'd7, e_btgt:64'h2000, e_jtgt:64'h2000, default:'0});
        vecs.push_back('{opcode:I, alu_op:4'd2, rs1_data:64'd1, imm:64'd63,
                         e_alu:64'h8000_0000_0000_0000, e_btgt:64'h3F, e_jtgt:64'h3F, default:'0});
        vecs.push_back('{opcode:R, alu_op:4'd3, rs1_data:M1, rs2_data:64'd1, e_alu:64'd1, default:'0});
        vecs.push_back('{opcode:R, alu_op:4'd4, rs1_data:M1, rs2_data:64'd1, e_alu:64'd0, default:'0});
        vecs.push_back('{opcode:RW, alu_op:4'd0, rs1_data:64'h7FFF_FFFF, rs2_data:64'd1,
                         e_alu:64'hFFFF_FFFF_8000_0000, default:'0});
        vecs.push_back('{opcode:I, alu_op:4'd7, rs1_data:64'h8000_0000_0000_0000, imm:64'd63,
                         e_alu:M1, e_btgt:64'h3F, e_jtgt:64'h3F, default:'0});
        vecs.push_back('{opcode:IW, alu_op:4'd6, rs1_data:64'hFFFF_FFFF_8000_0000, imm:64'd4,
                         e_alu:64'h0000_0000_0800_0000, e_btgt:64'd4, e_jtgt:64'd4, default:'0});
        vecs.push_back(v_blt);
        vecs.push_back('{opcode:7'b1100011, funct3:3'b100, is_branch:1'b1, rs1_data:M1, rs2_data:64'd1, pc:64'h100,
                         imm:64'h22, e_alu:64'h21, e_btgt:64'h122, e_jtgt:64'h122, e_exc:1'b1, default:'0});
        vecs.push_back('{opcode:7'b1100111, jump:1'b1, rs1_data:64'h1001, imm:64'd4, pc:64'h40, rd:5'd1, rwe:1'b1,
                         e_alu:64'h44, e_jt:1'b1, e_btgt:64'h44, e_jtgt:64'h1004, default:'0});
        vecs.push_back('{opcode:7'b1110011, funct3:3'b010, is_csr:1'b1, csr_read:1'b1, csr_write:1'b1,
                         csr_addr:12'h300, csr_rdata:64'hF0, rs1_data:64'h0F, rd:5'd5, rwe:1'b1, pc:64'h300,
                         e_alu:64'hF0, e_csrw:64'hFF, e_btgt:64'h300, e_jtgt:64'h300, default:'0});
        vecs.push_back('{opcode:7'b1110011, funct3:3'b111, is_csr:1'b1, csr_write:1'b1, csr_addr:12'h341,
                         csr_rdata:64'hFF, rs1:5'd3, rs1_data:64'hFFFF, pc:64'h304,
                         e_alu:64'hFF, e_csrw:64'hFC, e_btgt:64'h304, e_jtgt:64'h304, default:'0});
        vecs.push_back('{opcode:7'b0100011, funct3:3'b011, alu_op:4'd0, rs1_data:64'h1000, imm:64'd8,
                         rs2_data:64'hABCD, mem_write:1'b1, rwe:1'b1, trap_in:1'b1, trap_cause:4'd2, pc:64'h500,
                         e_alu:64'h1008, e_btgt:64'h508, e_jtgt:64'h508, e_exc:1'b1, e_cause:4'd2, default:'0});
        vecs.push_back('{opcode:7'b1101111, jump:1'b1, pc:64'h10, imm:64'd6, rd:5'd1, rwe:1'b1,
                         e_alu:64'h14, e_btgt:64'h16, e_jtgt:64'h16, e_exc:1'b1, default:'0});
        vecs.push_back('{opcode:7'b1100011, funct3:3'b111, is_branch:1'b1, rs1_data:64'd1, rs2_data:M1,
                         pc:64'h100, imm:64'h22, e_alu:64'h23, e_btgt:64'h122, e_jtgt:64'h122, default:'0});
        vecs.push_back('{opcode:R, alu_op:4'd12, rs1_data:64'h1234, rs2_data:64'h55, e_alu:64'd0, default:'0});
        vecs.push_back('{opcode:I, alu_op:4'd10, rs1_data:64'h99, imm:64'h1234, mem_read:1'b1, rwe:1'b1,
                         e_alu:64'h1234, e_btgt:64'h1234, e_jtgt:64'h1234, default:'0});
        vecs.push_back('{opcode:R, alu_op:4'd9, rs1_data:64'hF0F0, rs2_data:64'hFF00, e_alu:64'hF000, default:'0});
        vecs.push_back('{opcode:7'b0010111, alu_op:4'd0, use_pc:1'b1, pc:64'h8000, imm:64'h1000, rs1_data:64'd5,
                         e_alu:64'h9000, e_btgt:64'h9000, e_jtgt:64'h9000, default:'0});

        // Reset held for two edges with a live instruction on the inputs.
        resetn      = 1'b1;
        ex_if.stall = 1'b0;
        ex_if.flush = 1'b0;
        drive(v_add);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        drive('0);
        #1;
        check_regs("reset", zero_r);
        chk("reset.branch_taken", {63'd0, ex_if.branch_taken}, 64'd0);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Random register-register logic/arithmetic against a small model.
        for (int i = 0; i < 16; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            op = $urandom_range(0, 4);
            v  = '{opcode:R, rs1_data:a, rs2_data:b, rd:5'(i), rwe:1'b1, pc:{32'd0, $urandom} & 64'hFFFF_FFFC,
                   default:'0};
            case (op)
                0:       begin v.alu_op = 4'd0; e = a + b; end
                1:       begin v.alu_op = 4'd1; e = a - b; end
                2:       begin v.alu_op = 4'd5; e = a ^ b; end
                3:       begin v.alu_op = 4'd8; e = a | b; end
                default: begin v.alu_op = 4'd9; e = a & b; end
            endcase
            v.e_alu  = e;
            v.e_btgt = v.pc;
            v.e_jtgt = v.pc;
            apply($sformatf("rnd%0d", i), v);
        end

        // Stall: load ADD, then hold for three edges while a taken branch sits on the inputs.
        apply("stall_load", v_add);
        r_add = exp_of(v_add);
        @(negedge clk);
        drive(v_blt);
        ex_if.stall = 1'b1;
        #1;
        check_comb("stall", v_blt, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_regs($sformatf("stall_hold%0d", k), r_add);
        end

        // Flush alone produces a bubble and blanks the combinational view.
        @(negedge clk);
        ex_if.stall = 1'b0;
        ex_if.flush = 1'b1;
        #1;
        check_comb("flush", v_blt, 1'b1);
        @(posedge clk);
        #1;
        check_regs("flush", zero_r);

        // Flush outranks stall.
        apply("fs_load", v_add);
        @(negedge clk);
        ex_if.stall = 1'b1;
        ex_if.flush = 1'b1;
        @(posedge clk);
        #1;
        check_regs("flush_over_stall", zero_r);

        // Reset outranks stall.
        apply("rs_load", v_add);
        @(negedge clk);
        ex_if.stall = 1'b1;
        ex_if.flush = 1'b0;
        resetn      = 1'b1;
        @(posedge clk);
        #1;
        check_regs("reset_over_stall", zero_r);

        @(negedge clk);
        resetn      = 1'b0;
        ex_if.stall = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the in-order RISC-V (RV64I, Zicsr) pipeline, between decode and memory.
- Computes the ALU result, resolves branches and jumps, and forms CSR write data.
- Detects misaligned control-flow targets.
- Registers everything the memory stage needs in the EX/MEM pipeline register.

Parameters:
XLEN, 64, data/address width (64 only; W-ops assume 64)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  synchronous, active-high reset (asserted when 1)
- opcode  in  7  instruction opcode
- rd, rs1, rs2  in  5 each  register indices; rs1 is also the CSR uimm
- funct3  in  3  instruction funct3
- funct7  in  7  carried; unused (alu_op is authoritative)
- imm  in  XLEN  sign-extended immediate
- pc_in  in  XLEN  instruction PC
- alu_op  in  4  ALU op code (below)
- trap_cause_in  in  4  upstream trap cause
- csr_addr  in  12  CSR address
- is_csr, csr_read, csr_write  in  1 each  CSR controls
- trap_in  in  1  upstream trap
- reg_write_enable, mem_read, mem_write  in  1 each  write/load/store controls
- is_branch, jump, use_pc  in  1 each  branch, jump, operand A = PC
- rs1_data, rs2_data  in  XLEN each  register operands
- stall, flush  in  1 each  pipeline control
- csr_rdata  in  XLEN  current CSR value
- csr_addr_out  out  12  registered
- csr_wdata  out  XLEN  registered value to write to the CSR
- csr_read_out, csr_write_out  out  1 each  registered
- alu_result, rs2_data_out, pc_out  out  XLEN each  registered
- rd_out  out  5; funct3_out  out  3  registered
- reg_write_enable_out, mem_read_out, mem_write_out  out  1 each  registered
- trap_cause_out  out  4; trap_out  out  1  registered
- branch_taken  out  1; branch_target  out  XLEN  combinational
- jump_taken  out  1; jump_target  out  XLEN  combinational
- exception_occurred  out  1; exception_pc  out  XLEN; exception_cause  out  4  combinational

Behaviour:
- Operand A = use_pc ? pc_in : rs1_data.
- Operand B = rs2_data for opcode 0110011/0111011, else imm.
- alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (B), 11-15 give 0.
- Shift amount = B[5:0].
- W-ops (opcode 0011011/0111011): operate on low 32 bits, shift amount B[4:0], result sign-extended from bit 31.
- alu_result source: jump=1 gives pc_in+4; is_csr=1 gives csr_rdata; otherwise the ALU result.
- Branch compare on rs1_data vs rs2_data by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
- branch_target = pc_in+imm.
- jump_target: opcode 1100111 (JALR) gives (rs1_data+imm) with bit0 cleared; otherwise pc_in+imm.
- CSR source = rs1_data for funct3 0xx; the 5-bit rs1 index zero-extended for funct3 1xx.
- csr_wdata by funct3[1:0]: 01 gives src, 10 gives csr_rdata|src, 11 gives csr_rdata&~src.
- Misaligned = (branch taken or jump) and target[1]=1.
- exception_occurred = trap_in | misaligned.
- exception_cause = trap_in ? trap_cause_in : 0; exception_pc = pc_in.
- branch_taken = is_branch & condition & ~misaligned; jump_taken = jump & ~misaligned.
- stall=1 or flush=1 forces all combinational outputs to 0.
- Registers, priority resetn > flush > stall > load:
  - resetn=1: every registered output becomes 0 on the next edge.
  - flush=1: every registered output becomes 0 (bubble).
  - stall=1: all registered outputs hold.
  - Otherwise all registered outputs load; latency is 1 cycle.
- On load with exception_occurred=1:
  - trap_out=1, trap_cause_out=exception_cause.
  - reg_write_enable_out, mem_read_out, mem_write_out and csr_write_out are 0.
  - Remaining fields load normally.
- Pass-through on load: rd, funct3, pc_in, rs2_data, csr_addr and csr_read go to their _out registers unchanged.
- All arithmetic is modulo 2^XLEN.

Test Plan:
- Reset: resetn=1 for 2 edges, then 0 -> all registered outputs 0; branch_taken=0.
- ADD: alu_op=0, opcode 0110011, rs1_data=5, rs2_data=-7, rd=3, reg_write_enable=1 -> after 1 edge alu_result=0xFFFF_FFFF_FFFF_FFFE, rd_out=3, reg_write_enable_out=1.
- ADDW and SRA:
  - ADDW (opcode 0111011): rs1_data=0x7FFF_FFFF, rs2_data=1 -> alu_result=0xFFFF_FFFF_8000_0000.
  - SRA: rs1_data=0x8000_0000_0000_0000, imm=63 -> alu_result all ones.
- BLT: is_branch=1, funct3=100, rs1_data=-1, rs2_data=1, pc_in=0x100, imm=0x20 -> branch_taken=1, branch_target=0x120. With imm=0x22 -> branch_taken=0, exception_occurred=1, exception_cause=0.
- JALR: jump=1, opcode 1100111, rs1_data=0x1001, imm=4, pc_in=0x40 -> jump_target=0x1004, jump_taken=1, registered alu_result=0x44.
- CSRRS: funct3=010, csr_rdata=0xF0, rs1_data=0x0F -> csr_wdata=0xFF, alu_result=0xF0.
- Stall and flush: stall=1 -> outputs hold across 3 edges; then flush=1 -> all registered outputs 0.
